data_ram_slave: RTL

DATA_RAM_SLAVE -- requirements
Module: data_ram_slave

---
 rtl/data_ram_if.sv | 14 +
 rtl/data_ram_slave.sv | 81 ++++++++
 2 files changed

// File: rtl/data_ram_if.sv
// data_ram_if: load/store request bus between a core (master) and a data RAM (slave)
interface data_ram_if;
  logic rmem;
  logic wmem;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0] mem_type;
  logic mem_sign;
  logic busy;
  logic [31:0] mem_rdata;
  logic mem_err;
  modport master (output rmem, wmem, mem_addr, mem_wdata, mem_type, mem_sign, input busy, mem_rdata, mem_err);
  modport slave (input rmem, wmem, mem_addr, mem_wdata, mem_type, mem_sign, output busy, mem_rdata, mem_err);
endinterface

// File: rtl/data_ram_slave.sv
// data_ram_slave: multicycle word RAM with byte/half/word access, sign extension and fault detection
module data_ram_slave #(
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  data_ram_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  logic [1:0] state;
  logic [3:0] cnt;
  logic [31:0] l_addr, l_wdata;
  logic [1:0] l_type;
  logic l_sign, l_rmem, l_wmem;
  logic [31:0] mem [DEPTH];
  logic req, idle, go_resp, fault, e_sign, e_rmem, e_wmem;
  logic [31:0] e_addr, e_wdata, word, sh, ext, wr_data;
  logic [1:0] e_type;
  logic [3:0] be;
  logic [AW-1:0] idx;
  assign req = bus.rmem | bus.wmem;
  assign idle = state == IDLE;
  // In IDLE the live inputs are used so a LATENCY=1 access can complete on its first edge
  assign e_addr = idle ? bus.mem_addr : l_addr;
  assign e_wdata = idle ? bus.mem_wdata : l_wdata;
  assign e_type = idle ? bus.mem_type : l_type;
  assign e_sign = idle ? bus.mem_sign : l_sign;
  assign e_rmem = idle ? bus.rmem : l_rmem;
  assign e_wmem = idle ? bus.wmem : l_wmem;
  assign go_resp = !rst && req && ((idle && LATENCY == 1) || (state == WAIT && cnt == 4'd1));
  assign fault = (&e_type) || (e_type == 2'b01 && e_addr[0]) || (e_type == 2'b10 && |e_addr[1:0])
              || (|(e_addr >> (AW + 2))) || (e_rmem && e_wmem);
  assign idx = e_addr[AW+1:2];
  assign word = mem[idx];
  assign sh = word >> {e_addr[1:0], 3'b000};
  assign ext = e_type == 2'b00 ? {{24{e_sign & sh[7]}}, sh[7:0]}
             : e_type == 2'b01 ? {{16{e_sign & sh[15]}}, sh[15:0]} : sh;
  assign be = e_type == 2'b00 ? 4'b0001 << e_addr[1:0]
            : e_type == 2'b01 ? (e_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wr_data = e_type == 2'b00 ? {4{e_wdata[7:0]}}
                 : e_type == 2'b01 ? {2{e_wdata[15:0]}} : e_wdata;
  assign bus.busy = (idle && req) || state == WAIT;
  always_ff @(posedge clk)
    if (go_resp && e_wmem && !fault)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      l_addr <= '0;
      l_wdata <= '0;
      l_type <= '0;
      l_sign <= 1'b0;
      l_rmem <= 1'b0;
      l_wmem <= 1'b0;
      bus.mem_rdata <= '0;
      bus.mem_err <= 1'b0;
    end else begin
      if (idle && req) begin
        l_addr <= bus.mem_addr;
        l_wdata <= bus.mem_wdata;
        l_type <= bus.mem_type;
        l_sign <= bus.mem_sign;
        l_rmem <= bus.rmem;
        l_wmem <= bus.wmem;
        cnt <= CNT_INIT;
        state <= LATENCY == 1 ? RESP : WAIT;
      end else if (state == WAIT) begin
        state <= !req ? IDLE : cnt == 4'd1 ? RESP : WAIT;
        cnt <= cnt - 4'd1;
      end else if (state == RESP) state <= IDLE;
      if (go_resp) begin
        bus.mem_err <= fault;
        if (fault || e_rmem) bus.mem_rdata <= fault ? '0 : ext;
      end
    end
endmodule
